ldpc_bitflip_codec: RTL and testbench

Parametrised systematic LDPC-style ECC codec with one valid/ready request channel carrying both encode and decode requests.
- Decode uses iterative hard-decision bit-flipping over a fixed quasi-cyclic parity-check structure, with a bounded iteration count. The previous generation was single-shot and combinational and had no handshake.
- Adds backpressure, per-word status, and saturating error statistics.
- Sits between the datapath and storage/link interfaces.

---
 rtl/ldpc_pkg.sv | 61 ++++++
 rtl/ldpc_bitflip_core.sv | 42 ++++
 rtl/ldpc_bitflip_codec.sv | 161 ++++++++++++++++
 tb/tb_ldpc_bitflip_codec.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared types, H-structure constants and helper functions for the bit-flip codec
// Functions work on MAX_P-wide vectors; callers pass the real K and P so only the low bits matter.
package ldpc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_FLIP,
    S_OUT
  } state_e;

  // Check j covers data bit i when (j - i) mod P is one of these offsets.
  localparam int CHK_OFS0 = 0;
  localparam int CHK_OFS1 = 1;
  localparam int CHK_OFS2 = 3;

  // Upper bound on P supported by the helper functions.
  localparam int MAX_P = 32;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic       corrected;
    logic       uncorrectable;
    logic [3:0] iter;
  } status_t;

  function automatic logic covers(input int j, input int i, input int p);
    int d;
    d = (j - i + p) % p;
    return (d == CHK_OFS0) || (d == CHK_OFS1) || (d == CHK_OFS2);
  endfunction

  function automatic logic [MAX_P-1:0] parity_gen(input logic [MAX_P-1:0] data,
                                                  input int k, input int p);
    logic [MAX_P-1:0] par;
    par = '0;
    for (int j = 0; j < MAX_P; j++) begin
      for (int i = 0; i < MAX_P; i++) begin
        if (j < p && i < k && covers(j, i, p)) par[j] = par[j] ^ data[i];
      end
    end
    return par;
  endfunction

  function automatic logic [MAX_P-1:0] syndrome(input logic [MAX_P-1:0] data,
                                                input logic [MAX_P-1:0] par,
                                                input int k, input int p);
    return par ^ parity_gen(data, k, p);
  endfunction

  // Number of unsatisfied checks touching data bit i (0..3).
  function automatic logic [1:0] unsat_cnt(input logic [MAX_P-1:0] syn, input int i, input int p);
    logic [1:0] cnt;
    cnt = '0;
    cnt = cnt + {1'b0, syn[IDX_W'((i + CHK_OFS0) % p)]};
    cnt = cnt + {1'b0, syn[IDX_W'((i + CHK_OFS1) % p)]};
    cnt = cnt + {1'b0, syn[IDX_W'((i + CHK_OFS2) % p)]};
    return cnt;
  endfunction

endpackage

// File: rtl/ldpc_bitflip_core.sv
// rtl/ldpc_bitflip_core.sv - combinational syndrome and one bit-flip step
// Ports: work (codeword in), syn (syndrome), syn_nz (any check unsatisfied),
//        next_word (work after one flip step).
module ldpc_bitflip_core
  import ldpc_pkg::*;
#(
  parameter int K           = 8,
  parameter int P           = 8,
  parameter int FLIP_THRESH = 2
) (
  input  logic [K+P-1:0] work,
  output logic [P-1:0]   syn,
  output logic           syn_nz,
  output logic [K+P-1:0] next_word
);

  logic [MAX_P-1:0] data_ext;
  logic [MAX_P-1:0] par_ext;
  logic [MAX_P-1:0] syn_ext;
  logic [K-1:0]     flip;

  always_comb begin
    data_ext          = '0;
    data_ext[K-1:0]   = work[K-1:0];
    par_ext           = '0;
    par_ext[P-1:0]    = work[K+P-1:K];
    syn_ext           = syndrome(data_ext, par_ext, K, P);
    flip              = '0;
    for (int i = 0; i < K; i++) begin
      flip[i] = (unsat_cnt(syn_ext, i, P) >= 2'(FLIP_THRESH));
    end
  end

  assign syn    = syn_ext[P-1:0];
  assign syn_nz = |syn;

  // Data flips take priority; only when no data bit is suspicious enough do
  // we assume the error sits in the parity bits themselves.
  assign next_word = (|flip) ? (work ^ {{P{1'b0}}, flip})
                             : (work ^ {syn, {K{1'b0}}});

endmodule

// File: rtl/ldpc_bitflip_codec.sv
// rtl/ldpc_bitflip_codec.sv - handshaked LDPC-style encoder / iterative bit-flip decoder
// Ports: in_valid/in_ready/in_mode/in_word request channel; out_valid/out_ready/out_word
//        plus out_corrected/out_uncorrectable/out_iter result channel; saturating
//        cnt_corrected/cnt_uncorrectable with synchronous cnt_clr.
module ldpc_bitflip_codec
  import ldpc_pkg::*;
#(
  parameter int K           = 8,
  parameter int P           = 8,
  parameter int MAX_ITER    = 4,
  parameter int FLIP_THRESH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [K+P-1:0]   in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K+P-1:0]   out_word,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  output logic [3:0]       out_iter,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable,
  input  logic             cnt_clr
);

  localparam int N = K + P;

  state_e           state_q, state_d;
  logic [N-1:0]     work_q, work_d;
  logic [N-1:0]     orig_q, orig_d;
  logic [N-1:0]     out_word_q, out_word_d;
  logic [3:0]       iter_q, iter_d;
  status_t          stat_q, stat_d;
  logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
  logic [CNT_W-1:0] cnt_u_q, cnt_u_d;
  logic             inc_c, inc_u;

  logic [N-1:0]     core_in;
  logic [N-1:0]     core_next;
  logic [P-1:0]     syn;
  logic             syn_nz;

  // While idle the core sees the incoming data with zero parity, so its
  // syndrome is exactly the encoder parity; otherwise it checks the work word.
  assign core_in = (state_q == S_IDLE) ? {{P{1'b0}}, in_word[K-1:0]} : work_q;

  ldpc_bitflip_core #(
    .K          (K),
    .P          (P),
    .FLIP_THRESH(FLIP_THRESH)
  ) u_core (
    .work     (core_in),
    .syn      (syn),
    .syn_nz   (syn_nz),
    .next_word(core_next)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    orig_d     = orig_q;
    out_word_d = out_word_q;
    iter_d     = iter_q;
    stat_d     = stat_q;
    inc_c      = 1'b0;
    inc_u      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d = in_word;
          orig_d = in_word;
          iter_d = 4'd0;
          if (!in_mode) begin
            out_word_d = {syn, in_word[K-1:0]};
            stat_d     = '0;
            state_d    = S_OUT;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (!syn_nz) begin
          out_word_d           = work_q;
          stat_d.corrected     = (iter_q != 4'd0);
          stat_d.uncorrectable = 1'b0;
          stat_d.iter          = iter_q;
          inc_c                = (iter_q != 4'd0);
          state_d              = S_OUT;
        end else if (iter_q == 4'(MAX_ITER)) begin
          // Give up and hand back the received word untouched.
          out_word_d           = orig_q;
          stat_d.corrected     = 1'b0;
          stat_d.uncorrectable = 1'b1;
          stat_d.iter          = iter_q;
          inc_u                = 1'b1;
          state_d              = S_OUT;
        end else begin
          state_d = S_FLIP;
        end
      end
      S_FLIP: begin
        work_d  = core_next;
        iter_d  = iter_q + 4'd1;
        state_d = S_CHECK;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_c_d = cnt_c_q;
    cnt_u_d = cnt_u_q;
    if (cnt_clr) begin
      cnt_c_d = '0;
      cnt_u_d = '0;
    end else begin
      if (inc_c && cnt_c_q != {CNT_W{1'b1}}) cnt_c_d = cnt_c_q + CNT_W'(1);
      if (inc_u && cnt_u_q != {CNT_W{1'b1}}) cnt_u_d = cnt_u_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      orig_q     <= '0;
      out_word_q <= '0;
      iter_q     <= '0;
      stat_q     <= '0;
      cnt_c_q    <= '0;
      cnt_u_q    <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      orig_q     <= orig_d;
      out_word_q <= out_word_d;
      iter_q     <= iter_d;
      stat_q     <= stat_d;
      cnt_c_q    <= cnt_c_d;
      cnt_u_q    <= cnt_u_d;
    end
  end

  assign in_ready          = (state_q == S_IDLE);
  assign out_valid         = (state_q == S_OUT);
  assign out_word          = out_word_q;
  assign out_corrected     = stat_q.corrected;
  assign out_uncorrectable = stat_q.uncorrectable;
  assign out_iter          = stat_q.iter;
  assign cnt_corrected     = cnt_c_q;
  assign cnt_uncorrectable = cnt_u_q;

endmodule

// File: tb/tb_ldpc_bitflip_codec.sv
// tb/tb_ldpc_bitflip_codec.sv - scoreboard bench for ldpc_bitflip_codec (two configurations)
module tb_ldpc_bitflip_codec;

  localparam int N = 16;

  typedef struct {
    logic [15:0] w;
    logic        c;
    logic        u;
    logic [3:0]  it;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid      [2];
  logic        in_ready      [2];
  logic        in_mode       [2];
  logic [N-1:0] in_word      [2];
  logic        out_valid     [2];
  logic        out_ready     [2];
  logic [N-1:0] out_word     [2];
  logic        out_corrected [2];
  logic        out_unc       [2];
  logic [3:0]  out_iter      [2];
  logic        cnt_clr       [2];
  logic [15:0] cnt_c0, cnt_u0;
  logic [1:0]  cnt_c1, cnt_u1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  [2];
  logic prev_v   [2];

  ldpc_bitflip_codec #(.K(8), .P(8), .MAX_ITER(4), .FLIP_THRESH(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]), .in_word(in_word[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_word(out_word[0]),
    .out_corrected(out_corrected[0]), .out_uncorrectable(out_unc[0]), .out_iter(out_iter[0]),
    .cnt_corrected(cnt_c0), .cnt_uncorrectable(cnt_u0), .cnt_clr(cnt_clr[0])
  );

  ldpc_bitflip_codec #(.K(8), .P(8), .MAX_ITER(0), .FLIP_THRESH(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]), .in_word(in_word[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_word(out_word[1]),
    .out_corrected(out_corrected[1]), .out_uncorrectable(out_unc[1]), .out_iter(out_iter[1]),
    .cnt_corrected(cnt_c1), .cnt_uncorrectable(cnt_u1), .cnt_clr(cnt_clr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected result when a DUT raises out_valid.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst_n && out_valid[d] && !prev_v[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output dut%0d: got word %h, required no output", d, out_word[d]);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("dut%0d_word", d), 32'(out_word[d]), 32'(e.w));
          check($sformatf("dut%0d_corrected", d), 32'(out_corrected[d]), 32'(e.c));
          check($sformatf("dut%0d_uncorrectable", d), 32'(out_unc[d]), 32'(e.u));
          check($sformatf("dut%0d_iter", d), 32'(out_iter[d]), 32'(e.it));
          check($sformatf("dut%0d_latency", d), 32'(cyc - acc_cyc[d] + 1), 32'(e.lat));
        end
      end
      prev_v[d] <= rst_n ? out_valid[d] : 1'b0;
    end
  end

  task automatic send(input int d, input logic mode, input logic [15:0] word,
                      input logic [15:0] ew, input logic ec, input logic eu,
                      input logic [3:0] ei, input int el,
                      input bit expect_out, input bit clr_next);
    exp_t e;
    int   g;
    g = 0;
    while (!in_ready[d] && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready[d]) begin
      check($sformatf("dut%0d_ready_timeout", d), 32'(in_ready[d]), 32'd1);
      return;
    end
    if (expect_out) begin
      e.w = ew; e.c = ec; e.u = eu; e.it = ei; e.lat = el;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    in_valid[d] = 1'b1;
    in_mode[d]  = mode;
    in_word[d]  = word;
    @(posedge clk); #1;
    acc_cyc[d]  = cyc;
    // Garbage while busy must be ignored.
    in_valid[d] = 1'b0;
    in_mode[d]  = ~mode;
    in_word[d]  = 16'hDEAD;
    cnt_clr[d]  = clr_next;
    if (clr_next) begin
      @(posedge clk); #1;
      cnt_clr[d] = 1'b0;
    end
  endtask

  task automatic wait_done(input int d);
    int g;
    g = 0;
    while (((d == 0 ? q0.size() : q1.size()) != 0 || !in_ready[d]) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check($sformatf("dut%0d_done_timeout", d), 32'(g < 200), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_mode[d] = 1'b0; in_word[d] = '0;
      out_ready[d] = 1'b1; cnt_clr[d] = 1'b0; prev_v[d] = 1'b0; acc_cyc[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_out_valid%0d", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("rst_in_ready%0d", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("rst_out_word%0d", d), 32'(out_word[d]), 32'd0);
      check($sformatf("rst_flags%0d", d), 32'({out_corrected[d], out_unc[d]}), 32'd0);
      check($sformatf("rst_iter%0d", d), 32'(out_iter[d]), 32'd0);
    end
    check("rst_cnt0", 32'({cnt_c0, cnt_u0}), 32'd0);
    check("rst_cnt1", 32'({cnt_c1, cnt_u1}), 32'd0);

    // Encodes: latency 1, no flags.
    send(0, 1'b0, 16'h0001, 16'h0B01, 1'b0, 1'b0, 4'd0, 1, 1'b1, 1'b0); wait_done(0);
    send(0, 1'b0, 16'h00FF, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1, 1'b1, 1'b0); wait_done(0);
    send(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1, 1'b1, 1'b0); wait_done(0);
    check("enc_no_count", 32'({cnt_c0, cnt_u0}), 32'd0);

    // Decodes: clean, data-bit error, parity-bit error.
    send(0, 1'b1, 16'h0B01, 16'h0B01, 1'b0, 1'b0, 4'd0, 2, 1'b1, 1'b0); wait_done(0);
    check("clean_no_count", 32'(cnt_c0), 32'd0);
    send(0, 1'b1, 16'h0B05, 16'h0B01, 1'b1, 1'b0, 4'd1, 4, 1'b1, 1'b0); wait_done(0);
    check("cnt_corrected_1", 32'(cnt_c0), 32'd1);
    send(0, 1'b1, 16'h0A01, 16'h0B01, 1'b1, 1'b0, 4'd1, 4, 1'b1, 1'b0); wait_done(0);
    check("cnt_corrected_2", 32'(cnt_c0), 32'd2);
    check("cnt_unc_0", 32'(cnt_u0), 32'd0);

    // Backpressure: result held while out_ready is low.
    out_ready[0] = 1'b0;
    send(0, 1'b1, 16'h0B05, 16'h0B01, 1'b1, 1'b0, 4'd1, 4, 1'b1, 1'b0);
    g = 0;
    while (!out_valid[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("bp_valid_timeout", 32'(out_valid[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
      check("bp_hold_word", 32'(out_word[0]), 32'h0B01);
      check("bp_hold_flags", 32'({out_corrected[0], out_unc[0], out_iter[0]}), 32'h21);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    wait_done(0);
    check("cnt_corrected_3", 32'(cnt_c0), 32'd3);

    // MAX_ITER = 0: detect only, narrow saturating counters.
    send(1, 1'b1, 16'h0B01, 16'h0B01, 1'b0, 1'b0, 4'd0, 2, 1'b1, 1'b0); wait_done(1);
    send(1, 1'b1, 16'h0B05, 16'h0B05, 1'b0, 1'b1, 4'd0, 2, 1'b1, 1'b0); wait_done(1);
    check("cnt_unc1_1", 32'(cnt_u1), 32'd1);
    send(1, 1'b1, 16'h0B05, 16'h0B05, 1'b0, 1'b1, 4'd0, 2, 1'b1, 1'b1); wait_done(1);
    check("cnt_clr_priority", 32'(cnt_u1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      send(1, 1'b1, 16'h0A01, 16'h0A01, 1'b0, 1'b1, 4'd0, 2, 1'b1, 1'b0); wait_done(1);
    end
    check("cnt_unc1_saturate", 32'(cnt_u1), 32'd3);
    check("cnt_corr1_zero", 32'(cnt_c1), 32'd0);

    // Reset during FLIP aborts with no output.
    send(0, 1'b1, 16'h0B05, 16'h0000, 1'b0, 1'b0, 4'd0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(in_ready[0]), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("post_rst_cnt0", 32'({cnt_c0, cnt_u0}), 32'd0);
    check("post_rst_cnt1", 32'({cnt_c1, cnt_u1}), 32'd0);

    // Recovery after reset.
    @(posedge clk); #1;
    send(0, 1'b0, 16'h0001, 16'h0B01, 1'b0, 1'b0, 4'd0, 1, 1'b1, 1'b0); wait_done(0);

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
